vga_frame_reader: RTL and testbench
===================================

// Module: vga_frame_reader
// PURPOSE
//   Sequences the on-chip frame memory (1024-bit words, 128 x 8-bit gray pixels per word) into the
//   VGA controller's Avalon-ST sink as one packet per frame. Issues word reads, prefetches the next
//   word into a second buffer while serialising the current one, expands each 8-bit gray pixel to
//   30-bit RGB and drives sop/eop. Sits between the processed-image memory and the VGA controller.
// PARAMETERS
//   ADDR_W          6     memory word address width
//   WORDS_PER_FRAME 64    words per frame; last address = WORDS_PER_FRAME-1
//   PIX_PER_WORD    128   pixels per memory word
//   PIX_W           8     bits per gray pixel; DATA_W = PIX_PER_WORD*PIX_W = 1024
//   READ_LATENCY    1     cycles from address/chipselect to valid readdata (1 or 2)
// PORTS
//   clk_clk               in   1       single clock
//   reset_reset           in   1       synchronous, active-high reset
//   start                 in   1       pulse: begin a frame (sampled only when idle)
//   continuous            in   1       1: restart next frame automatically after eop
//   busy                  out  1       frame in progress
//   frame_done            out  1       1-cycle pulse after eop beat accepted
//   mem_address           out  ADDR_W  word address
//   mem_chipselect        out  1       read strobe (1 cycle per word)
//   mem_clken             out  1       tied 1
//   mem_write             out  1       tied 0
//   mem_byteenable        out  128     tied all ones
//   mem_writedata         out  1024    tied 0
//   mem_readdata          in   1024    read data, valid READ_LATENCY cycles after chipselect
//   vga_data              out  30      {R[9:0],G[9:0],B[9:0]}
//   vga_startofpacket     out  1       first pixel of frame
//   vga_endofpacket       out  1       last pixel of frame
//   vga_valid             out  1       beat valid
//   vga_ready             in   1       sink ready
// BEHAVIOUR
//   - Reset: all outputs 0 except mem_clken=1, mem_byteenable all ones; FSM IDLE, both buffers empty,
//     word/pixel counters 0. Reset mid-frame aborts: next cycle vga_valid=0, no read pending honoured.
//   - FSM: IDLE -(start)-> FETCH0 -> WAIT0 -> STREAM -(eop accepted)-> IDLE, or back to STREAM when
//     continuous=1 and word 0 already prefetched. start while busy is ignored.
//   - Reads: chipselect high exactly 1 cycle per word; data captured READ_LATENCY cycles later.
//     At most one read outstanding. Prefetch of word n+1 issued the cycle after word n enters cur
//     buffer when next buffer empty; in continuous mode address wraps WORDS_PER_FRAME-1 -> 0.
//   - Latency (READ_LATENCY=1): start sampled edge T -> chipselect/address 0 in cycle T+1 ->
//     cur loaded at T+2 -> vga_valid=1 with sop in cycle T+3.
//   - Serialisation: pixel i = cur[PIX_W*i +: PIX_W], i=0 first. Beat advances only on
//     vga_valid & vga_ready. While valid & !ready, data/sop/eop held stable.
//   - On accept of pixel PIX_PER_WORD-1: cur <= next same cycle if next full, so no bubble
//     (guaranteed when PIX_PER_WORD > READ_LATENCY+1). If next empty, valid drops until data lands.
//   - Colour: each channel = {p, p[7:6]} (8->10 bit replicate); 0x00->0, 0xFF->10'h3FF.
//   - sop = word 0 pixel 0; eop = word WORDS_PER_FRAME-1 pixel PIX_PER_WORD-1.
//   - busy: 1 from cycle after start sampled until frame_done cycle (inclusive of frame_done 0).
//   - continuous cleared mid-frame: current frame completes, then IDLE; no word-0 prefetch issued
//     after the flag is seen low at last-word fetch time (any prefetched word 0 discarded).
// TESTING
//   1. Assert reset 3 cycles mid-stream -> next cycle vga_valid=0, chipselect=0, busy=0, address=0.
//   2. Memory word k pixel i = (k*128+i)&0xFF, ready=1, one start -> 8192 beats, no gaps after first;
//      beat0 data 30'h0 with sop; beat 255 data 30'h3FFFFFFF; beat 8191 eop; frame_done next cycle.
//   3. Same image, ready random 50% -> identical beat sequence; data/sop/eop stable while stalled.
//   4. continuous=1 for 2 frames -> second sop on cycle immediately following first eop accept;
//      clear continuous in frame 2 -> stops after its eop, busy falls.
//   5. start pulsed at beat 100 of a running frame -> ignored; total beats still 8192, one sop.
//   6. Whole run: mem_write never 1; chipselect count = 64 per frame; never 2 reads outstanding.

Source files
------------

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - streams a gray frame from word memory into a VGA Avalon-ST sink
module vga_frame_reader #(
    parameter int ADDR_W          = 6,
    parameter int WORDS_PER_FRAME = 64,
    parameter int PIX_PER_WORD    = 128,
    parameter int PIX_W           = 8,
    parameter int READ_LATENCY    = 1
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset,
    input  logic                                start,
    input  logic                                continuous,
    output logic                                busy,
    output logic                                frame_done,
    output logic [ADDR_W-1:0]                   mem_address,
    output logic                                mem_chipselect,
    output logic                                mem_clken,
    output logic                                mem_write,
    output logic [PIX_PER_WORD*PIX_W/8-1:0]     mem_byteenable,
    output logic [PIX_PER_WORD*PIX_W-1:0]       mem_writedata,
    input  logic [PIX_PER_WORD*PIX_W-1:0]       mem_readdata,
    output logic [29:0]                         vga_data,
    output logic                                vga_startofpacket,
    output logic                                vga_endofpacket,
    output logic                                vga_valid,
    input  logic                                vga_ready
);

    localparam int DATA_W    = PIX_PER_WORD * PIX_W;
    localparam int PIX_IDX_W = $clog2(PIX_PER_WORD);
    localparam logic [ADDR_W-1:0]       LAST_WORD = ADDR_W'(WORDS_PER_FRAME - 1);
    localparam logic [PIX_IDX_W-1:0]    LAST_PIX  = PIX_IDX_W'(PIX_PER_WORD - 1);
    // Bit of the read pipe whose data is on mem_readdata this cycle
    localparam logic [READ_LATENCY-1:0] LAND_MASK = READ_LATENCY'(1) << (READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH0, S_WAIT0, S_STREAM} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_cs;
    logic [READ_LATENCY-1:0]   r_pipe;
    logic [ADDR_W-1:0]         r_addr;
    logic [ADDR_W-1:0]         r_fetch_addr;
    logic                      r_fetch_done;
    logic [DATA_W-1:0]         r_cur;
    logic [DATA_W-1:0]         r_nxt;
    logic                      r_cur_full;
    logic                      r_nxt_full;
    logic [ADDR_W-1:0]         r_cur_word;
    logic [ADDR_W-1:0]         r_nxt_word;
    logic [PIX_IDX_W-1:0]      r_pix_idx;
    logic                      r_done;

    logic                      w_acc;
    logic                      w_last_pix;
    logic                      w_word_done;
    logic                      w_sop;
    logic                      w_eop;
    logic                      w_eop_acc;
    logic                      w_land;
    logic                      w_inflight;
    logic                      w_go_idle;
    logic                      w_nxt_free;
    logic                      w_issue_first;
    logic                      w_issue;
    logic [ADDR_W-1:0]         w_issue_addr;
    logic [PIX_W-1:0]          w_pix;
    logic [PIX_W+1:0]          w_chan;

    assign w_acc       = r_cur_full & vga_ready;
    assign w_last_pix  = (r_pix_idx == LAST_PIX);
    assign w_word_done = w_acc & w_last_pix;
    assign w_sop       = r_cur_full & (r_cur_word == '0) & (r_pix_idx == '0);
    assign w_eop       = r_cur_full & (r_cur_word == LAST_WORD) & w_last_pix;
    assign w_eop_acc   = w_acc & w_eop;
    assign w_land      = r_pipe[READ_LATENCY-1];
    assign w_inflight  = r_cs | (|(r_pipe & ~LAND_MASK));

    // Next buffer is free after this edge unless landing data is parked there
    assign w_nxt_free  = (!r_nxt_full | w_word_done) & !(w_land & r_cur_full & !w_word_done);

    assign w_issue_first = (r_state == S_IDLE) & start;
    assign w_issue       = w_issue_first |
                           ((r_state != S_IDLE) & !w_go_idle & !r_fetch_done & !w_inflight & w_nxt_free);
    assign w_issue_addr  = w_issue_first ? '0 : r_fetch_addr;

    // Next-state: a frame wraps straight into the next only when word 0 is already waiting
    always_comb begin
        w_state_nxt = r_state;
        w_go_idle   = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_FETCH0;
            S_FETCH0: w_state_nxt = S_WAIT0;
            S_WAIT0:  if (w_land) w_state_nxt = S_STREAM;
            S_STREAM: begin
                if (w_eop_acc && !(continuous && r_nxt_full)) begin
                    w_state_nxt = S_IDLE;
                    w_go_idle   = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register and end-of-frame pulse
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_eop_acc;
        end
    end

    // Read issue: one strobe per word, one read in flight, fetch stops at last word unless continuous
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cs         <= 1'b0;
            r_pipe       <= '0;
            r_addr       <= '0;
            r_fetch_addr <= '0;
            r_fetch_done <= 1'b0;
        end else begin
            r_cs   <= w_issue;
            r_pipe <= w_go_idle ? '0 : ((r_pipe << 1) | READ_LATENCY'(r_cs));
            if (w_issue) begin
                r_addr <= w_issue_addr;
                if (w_issue_addr == LAST_WORD) begin
                    r_fetch_addr <= '0;
                    r_fetch_done <= !continuous;
                end else begin
                    r_fetch_addr <= w_issue_addr + 1'b1;
                    r_fetch_done <= 1'b0;
                end
            end
        end
    end

    // Double buffer: landing data fills cur if it is (or is about to be) empty, else next
    always_ff @(posedge clk_clk) begin
        if (reset_reset || w_go_idle) begin
            r_cur_full <= 1'b0;
            r_nxt_full <= 1'b0;
            r_cur_word <= '0;
            r_nxt_word <= '0;
            r_pix_idx  <= '0;
        end else if (w_word_done) begin
            r_pix_idx <= '0;
            if (r_nxt_full) begin
                r_cur      <= r_nxt;
                r_cur_word <= r_nxt_word;
                r_nxt_full <= 1'b0;
            end else if (w_land) begin
                r_cur      <= mem_readdata;
                r_cur_word <= r_addr;
            end else begin
                r_cur_full <= 1'b0;
            end
        end else begin
            if (w_acc) r_pix_idx <= r_pix_idx + 1'b1;
            if (w_land) begin
                if (r_cur_full) begin
                    r_nxt      <= mem_readdata;
                    r_nxt_word <= r_addr;
                    r_nxt_full <= 1'b1;
                end else begin
                    r_cur      <= mem_readdata;
                    r_cur_word <= r_addr;
                    r_cur_full <= 1'b1;
                end
            end
        end
    end

    assign w_pix  = r_cur[PIX_W*r_pix_idx +: PIX_W];
    assign w_chan = {w_pix, w_pix[PIX_W-1 -: 2]};

    assign vga_valid         = r_cur_full;
    assign vga_data          = r_cur_full ? {w_chan, w_chan, w_chan} : '0;
    assign vga_startofpacket = w_sop;
    assign vga_endofpacket   = w_eop;
    assign busy              = (r_state != S_IDLE);
    assign frame_done        = r_done;
    assign mem_address       = r_addr;
    assign mem_chipselect    = r_cs;
    assign mem_clken         = 1'b1;
    assign mem_write         = 1'b0;
    assign mem_byteenable    = '1;
    assign mem_writedata     = '0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - scoreboard bench for vga_frame_reader
module tb_vga_frame_reader;

    localparam int ADDR_W = 6;
    localparam int WPF    = 64;
    localparam int PPW    = 128;
    localparam int DATA_W = 1024;

    logic                 clk_clk = 1'b0;
    logic                 reset_reset;
    logic                 start;
    logic                 continuous;
    logic                 busy;
    logic                 frame_done;
    logic [ADDR_W-1:0]    mem_address;
    logic                 mem_chipselect;
    logic                 mem_clken;
    logic                 mem_write;
    logic [127:0]         mem_byteenable;
    logic [DATA_W-1:0]    mem_writedata;
    logic [DATA_W-1:0]    mem_readdata;
    logic [29:0]          vga_data;
    logic                 vga_startofpacket;
    logic                 vga_endofpacket;
    logic                 vga_valid;
    logic                 vga_ready = 1'b1;

    always #5 clk_clk = ~clk_clk;

    vga_frame_reader dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .continuous(continuous),
        .busy(busy), .frame_done(frame_done), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .vga_data(vga_data),
        .vga_startofpacket(vga_startofpacket), .vga_endofpacket(vga_endofpacket),
        .vga_valid(vga_valid), .vga_ready(vga_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: one-cycle read latency, garbage on the bus when no read is returning
    logic [DATA_W-1:0] mem [0:WPF-1];
    always @(posedge clk_clk)
        mem_readdata <= mem_chipselect ? mem[mem_address] : {32{32'($urandom)}};

    bit rand_ready = 1'b0;
    initial forever begin
        @(posedge clk_clk); #1;
        vga_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [31:0] exp_q[$];

    task automatic push_frame();
        for (int k = 0; k < WPF; k++) begin
            for (int i = 0; i < PPW; i++) begin
                logic [7:0] p;
                logic [9:0] c;
                p = 8'((k * 128 + i) % 256);
                c = {p, 2'(p >> 6)};
                exp_q.push_back({(k == 0 && i == 0), (k == WPF-1 && i == PPW-1), c, c, c});
            end
        end
    endtask

    int   cyc = 0, cs_count = 0, wr_count = 0, beats = 0, sop_count = 0, gap_count = 0;
    int   beat_idx = -1;
    int   last_eop_cyc = -1;
    bit   b2b_expect = 1'b0;
    bit   in_frame = 1'b0, prev_stall = 1'b0, eop_prev = 1'b0, prev_cs = 1'b0;
    logic [32:0] prev_beat = '0;

    // Output monitor: pops the scoreboard on every accepted beat
    always @(negedge clk_clk) begin
        cyc++;
        if (reset_reset) begin
            in_frame   = 1'b0;
            prev_stall = 1'b0;
            eop_prev   = 1'b0;
            prev_cs    = 1'b0;
        end else begin
            if (mem_write) wr_count++;
            if (mem_chipselect) begin
                cs_count++;
                check("one_read_outstanding", prev_cs, 0);
            end
            if (frame_done || eop_prev) check("frame_done_after_eop", frame_done, eop_prev);
            if (prev_stall)
                check("hold_while_stalled",
                      {vga_valid, vga_startofpacket, vga_endofpacket, vga_data}, prev_beat);
            if (in_frame && !vga_valid) gap_count++;
            eop_prev = 1'b0;
            if (vga_valid && vga_ready) begin
                beats++;
                if (vga_startofpacket) begin
                    sop_count++;
                    beat_idx = 0;
                    in_frame = 1'b1;
                    if (b2b_expect && last_eop_cyc >= 0)
                        check("sop_right_after_eop", cyc - last_eop_cyc, 1);
                end
                if (beat_idx == 0)   check("beat0_black", vga_data, 30'h0);
                if (beat_idx == 255) check("beat255_white", vga_data, 30'h3FFFFFFF);
                if (vga_endofpacket) begin
                    check("eop_beat_index", beat_idx, 8191);
                    last_eop_cyc = cyc;
                    eop_prev     = 1'b1;
                    in_frame     = 1'b0;
                end
                if (exp_q.size() == 0) check("beat_expected", exp_q.size(), 1);
                else check("beat", {vga_startofpacket, vga_endofpacket, vga_data}, exp_q.pop_front());
                beat_idx++;
            end
            prev_stall = vga_valid && !vga_ready;
            prev_beat  = {vga_valid, vga_startofpacket, vga_endofpacket, vga_data};
            prev_cs    = mem_chipselect;
        end
    end

    task automatic pulse_start();
        @(posedge clk_clk); #1; start = 1'b1;
        @(posedge clk_clk); #1; start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk_clk); #1;
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk_clk); #1;
            n++;
        end
        check(tag, beats >= target, 1);
    endtask

    int cs0, s0, b0;

    initial begin
        for (int k = 0; k < WPF; k++)
            for (int i = 0; i < PPW; i++)
                mem[k][i*8 +: 8] = 8'((k * 128 + i) % 256);
        reset_reset = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        check("rst_valid", vga_valid, 0);
        check("rst_sop_eop", {vga_startofpacket, vga_endofpacket}, 0);
        check("rst_data", vga_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_chipselect", mem_chipselect, 0);
        check("rst_address", mem_address, 0);
        check("rst_clken", mem_clken, 1);
        check("rst_write", mem_write, 0);
        check("rst_byteenable", mem_byteenable == '1, 1);
        check("rst_writedata", mem_writedata == '0, 1);
        reset_reset = 1'b0;

        // Single frame, ready always high: latency and gapless stream
        push_frame();
        cs0 = cs_count;
        pulse_start();
        check("lat_t1_chipselect", mem_chipselect, 1);
        check("lat_t1_address", mem_address, 0);
        check("lat_t1_busy", busy, 1);
        check("lat_t1_valid", vga_valid, 0);
        @(posedge clk_clk); #1;
        check("lat_t2_valid", vga_valid, 0);
        @(posedge clk_clk); #1;
        check("lat_t3_valid", vga_valid, 1);
        check("lat_t3_sop", vga_startofpacket, 1);
        wait_idle("full_frame_idle", 9000);
        check("busy_low_with_frame_done", frame_done, 1);
        repeat (3) @(posedge clk_clk);
        #1;
        check("full_frame_sb_empty", exp_q.size(), 0);
        check("full_frame_reads", cs_count - cs0, 64);
        check("full_frame_gaps", gap_count, 0);

        // Random backpressure
        rand_ready = 1'b1;
        push_frame();
        cs0 = cs_count;
        pulse_start();
        wait_idle("stall_frame_idle", 20000);
        repeat (3) @(posedge clk_clk);
        #1;
        rand_ready = 1'b0;
        check("stall_frame_sb_empty", exp_q.size(), 0);
        check("stall_frame_reads", cs_count - cs0, 64);

        // start while busy is ignored
        push_frame();
        b0 = beats;
        s0 = sop_count;
        pulse_start();
        wait_beats("reach_beat100", b0 + 100, 500);
        pulse_start();
        wait_idle("ignored_start_idle", 9000);
        repeat (5) @(posedge clk_clk);
        #1;
        check("ignored_start_beats", beats - b0, 8192);
        check("ignored_start_sops", sop_count - s0, 1);
        check("ignored_start_busy", busy, 0);
        check("ignored_start_sb_empty", exp_q.size(), 0);

        // Continuous mode for two frames, flag cleared during the second
        push_frame();
        push_frame();
        continuous   = 1'b1;
        b2b_expect   = 1'b1;
        last_eop_cyc = -1;
        b0  = beats;
        s0  = sop_count;
        cs0 = cs_count;
        pulse_start();
        wait_beats("cont_reach_frame2", b0 + 9192, 12000);
        continuous = 1'b0;
        wait_idle("cont_idle", 12000);
        repeat (5) @(posedge clk_clk);
        #1;
        b2b_expect = 1'b0;
        check("cont_beats", beats - b0, 16384);
        check("cont_sops", sop_count - s0, 2);
        check("cont_reads", cs_count - cs0, 128);
        check("cont_sb_empty", exp_q.size(), 0);
        check("cont_gaps", gap_count, 0);

        // Reset mid-stream, then a clean frame
        push_frame();
        b0 = beats;
        pulse_start();
        wait_beats("reach_beat300", b0 + 300, 1000);
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        check("midrst_valid", vga_valid, 0);
        check("midrst_chipselect", mem_chipselect, 0);
        check("midrst_busy", busy, 0);
        check("midrst_address", mem_address, 0);
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        exp_q.delete();
        cs0 = cs_count;
        b0  = beats;
        repeat (10) @(posedge clk_clk);
        #1;
        check("postrst_quiet_beats", beats - b0, 0);
        check("postrst_quiet_reads", cs_count - cs0, 0);
        check("postrst_busy", busy, 0);
        push_frame();
        pulse_start();
        wait_idle("recovery_idle", 9000);
        repeat (3) @(posedge clk_clk);
        #1;
        check("recovery_sb_empty", exp_q.size(), 0);
        check("recovery_reads", cs_count - cs0, 64);

        check("mem_write_never", wr_count, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
